mux_nto1_reg: RTL and testbench

- Parametrised, registered N-to-1 multiplexer. Generalises the team's combinational 4:1 mux to NUM_CH channels of WIDTH bits.
- Adds per-channel valid/ready handshakes, a single-entry output register with backpressure, and two select modes:
  - direct: the select input chooses the channel.
  - scan: a round-robin arbiter chooses the channel.
- Sits between multiple producer channels and a single downstream consumer.

---
 rtl/mux_nto1_reg.sv | 105 ++++++++++
 tb/tb_mux_nto1_reg.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mux_nto1_reg.sv
// Registered N-to-1 mux with per-channel valid/ready, direct or round-robin select.
// Optional MUX_NTO1_XFER_CNT_EN adds a saturating input-transfer counter (xfer_cnt, cnt_clr).
module mux_nto1_reg #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] i,
  input  logic [NUM_CH-1:0]       i_valid,
  output logic [NUM_CH-1:0]       i_ready,
  input  logic [SEL_W-1:0]        s,
  input  logic                    mode,
  output logic [WIDTH-1:0]        y,
  output logic                    y_valid,
  input  logic                    y_ready,
  output logic [SEL_W-1:0]        y_ch
`ifdef MUX_NTO1_XFER_CNT_EN
  ,
  input  logic                    cnt_clr,
  output logic [15:0]             xfer_cnt
`endif
);

  localparam int unsigned PW    = SEL_W + 1;
  localparam int unsigned CNT_W = 16;

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] scan_src;
  logic             scan_ok;
  logic [PW-1:0]    sum;
  logic [SEL_W-1:0] src;
  logic             src_ok;
  logic             direct_ok;
  logic             load;
  logic             xfer;
  logic [WIDTH-1:0] src_data;

  // Round-robin search starting at ptr, wrapping modulo NUM_CH.
  always_comb begin
    scan_src = '0;
    scan_ok  = 1'b0;
    sum      = '0;
    for (int unsigned off = 0; off < NUM_CH; off++) begin
      sum = {1'b0, ptr} + PW'(off);
      if (sum >= PW'(NUM_CH)) sum = sum - PW'(NUM_CH);
      if (!scan_ok && i_valid[sum[SEL_W-1:0]]) begin
        scan_src = sum[SEL_W-1:0];
        scan_ok  = 1'b1;
      end
    end
  end

  assign direct_ok = ({1'b0, s} < PW'(NUM_CH));
  assign src       = mode ? scan_src : s;
  assign src_ok    = mode ? scan_ok : direct_ok;
  assign load      = ~y_valid | y_ready;

  // Grant only the selected channel; forced low while reset is asserted.
  always_comb begin
    i_ready  = '0;
    src_data = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (src == SEL_W'(k)) begin
        i_ready[k] = rst_n & load & src_ok;
        src_data   = i[k*WIDTH +: WIDTH];
      end
    end
  end

  assign xfer = |(i_ready & i_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y       <= '0;
      y_valid <= 1'b0;
      y_ch    <= '0;
      ptr     <= '0;
    end else if (xfer) begin
      y       <= src_data;
      y_ch    <= src;
      y_valid <= 1'b1;
      if (mode) ptr <= (src == SEL_W'(NUM_CH - 1)) ? '0 : src + SEL_W'(1);
    end else if (y_ready) begin
      y_valid <= 1'b0;
    end
  end

`ifdef MUX_NTO1_XFER_CNT_EN
  // Saturating transfer counter; clear has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (cnt_clr) begin
      xfer_cnt <= '0;
    end else if (xfer && (xfer_cnt != {CNT_W{1'b1}})) begin
      xfer_cnt <= xfer_cnt + CNT_W'(1);
    end
  end
`else
  // Counter absent in this build.
`endif

endmodule

// File: tb/tb_mux_nto1_reg.sv
// Directed bench for mux_nto1_reg: 4-channel table vectors plus multi-cycle sequences,
// and a 3-channel instance for out-of-range direct select.
module tb_mux_nto1_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // 4-channel instance
  logic [31:0] i4;
  logic [3:0]  iv4, rdy4;
  logic [1:0]  s4, ych4;
  logic        mode4, yv4, yr4;
  logic [7:0]  y4;
`ifdef MUX_NTO1_XFER_CNT_EN
  logic        cnt_clr;
  logic [15:0] xfer_cnt;
`endif

  // 3-channel instance
  logic [23:0] i3;
  logic [2:0]  iv3, rdy3;
  logic [1:0]  s3, ych3;
  logic        mode3, yv3, yr3;
  logic [7:0]  y3;

  mux_nto1_reg #(.WIDTH(8), .NUM_CH(4), .SEL_W(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .i(i4), .i_valid(iv4), .i_ready(rdy4), .s(s4),
    .mode(mode4), .y(y4), .y_valid(yv4), .y_ready(yr4), .y_ch(ych4)
`ifdef MUX_NTO1_XFER_CNT_EN
    , .cnt_clr(cnt_clr), .xfer_cnt(xfer_cnt)
`endif
  );

  mux_nto1_reg #(.WIDTH(8), .NUM_CH(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .i(i3), .i_valid(iv3), .i_ready(rdy3), .s(s3),
    .mode(mode3), .y(y3), .y_valid(yv3), .y_ready(yr3), .y_ch(ych3)
`ifdef MUX_NTO1_XFER_CNT_EN
    , .cnt_clr(1'b0), .xfer_cnt()
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic       mode;
    logic [1:0] s;
    logic [3:0] iv;
    logic [3:0] rdy;
    logic       yv;
    logic [7:0] y;
    logic [1:0] ych;
  } vec_t;

  vec_t tbl [10];
  logic [7:0] dat [4];

  initial begin
    dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'hA5; dat[3] = 8'h3C;
    // y_ready held 1 throughout the table; ptr starts at 0
    tbl[0] = '{1'b0, 2'd2, 4'b1111, 4'b0100, 1'b1, 8'hA5, 2'd2};
    tbl[1] = '{1'b0, 2'd0, 4'b1111, 4'b0001, 1'b1, 8'h11, 2'd0};
    tbl[2] = '{1'b0, 2'd3, 4'b0111, 4'b1000, 1'b0, 8'h11, 2'd0};
    tbl[3] = '{1'b0, 2'd1, 4'b0010, 4'b0010, 1'b1, 8'h22, 2'd1};
    tbl[4] = '{1'b1, 2'd0, 4'b1111, 4'b0001, 1'b1, 8'h11, 2'd0};
    tbl[5] = '{1'b1, 2'd0, 4'b1001, 4'b1000, 1'b1, 8'h3C, 2'd3};
    tbl[6] = '{1'b1, 2'd0, 4'b0000, 4'b0000, 1'b0, 8'h3C, 2'd3};
    tbl[7] = '{1'b0, 2'd1, 4'b1111, 4'b0010, 1'b1, 8'h22, 2'd1};
    tbl[8] = '{1'b1, 2'd0, 4'b0110, 4'b0010, 1'b1, 8'h22, 2'd1};
    tbl[9] = '{1'b1, 2'd0, 4'b0011, 4'b0001, 1'b1, 8'h11, 2'd0};

    i4 = {dat[3], dat[2], dat[1], dat[0]};
    i3 = {8'h33, 8'h22, 8'h11};
    iv4 = 4'b1111; s4 = 2'd2; mode4 = 1'b0; yr4 = 1'b1;
    iv3 = 3'b000; s3 = 2'd0; mode3 = 1'b0; yr3 = 1'b1;
`ifdef MUX_NTO1_XFER_CNT_EN
    cnt_clr = 1'b0;
`endif
    rst_n = 1'b0;
    #1;
    chk("rst_y", 32'(y4), 0);
    chk("rst_yv", 32'(yv4), 0);
    chk("rst_ych", 32'(ych4), 0);
    chk("rst_rdy", 32'(rdy4), 0);
    tick();
    tick();
    rst_n = 1'b1;

    // Single-cycle vectors
    for (int n = 0; n < 10; n++) begin
      mode4 = tbl[n].mode; s4 = tbl[n].s; iv4 = tbl[n].iv; yr4 = 1'b1;
      #1;
      chk($sformatf("vec%0d_rdy", n), 32'(rdy4), 32'(tbl[n].rdy));
      tick();
      chk($sformatf("vec%0d_yv", n), 32'(yv4), 32'(tbl[n].yv));
      chk($sformatf("vec%0d_y", n), 32'(y4), 32'(tbl[n].y));
      chk($sformatf("vec%0d_ych", n), 32'(ych4), 32'(tbl[n].ych));
    end

    // Reset while the output register is full
    mode4 = 1'b0; s4 = 2'd2; iv4 = 4'b1111; yr4 = 1'b1;
    tick();
    chk("pre_rst_yv", 32'(yv4), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_y", 32'(y4), 0);
    chk("mid_rst_yv", 32'(yv4), 0);
    chk("mid_rst_ych", 32'(ych4), 0);
    chk("mid_rst_rdy", 32'(rdy4), 0);
    tick();
    rst_n = 1'b1;

    // Fairness: all valid, grants rotate from channel 0
    mode4 = 1'b1; iv4 = 4'b1111; yr4 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("fair%0d_rdy", k), 32'(rdy4), 32'(1 << (k % 4)));
      tick();
      chk($sformatf("fair%0d_ych", k), 32'(ych4), 32'(k % 4));
      chk($sformatf("fair%0d_y", k), 32'(y4), 32'(dat[k % 4]));
      chk($sformatf("fair%0d_yv", k), 32'(yv4), 1);
    end

    // Skipping: move ptr to 1, then only channels 0 and 3 valid
    iv4 = 4'b0001;
    tick();
    iv4 = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("skip%0d_ych", k), 32'(ych4), (k % 2 == 0) ? 3 : 0);
    end

    // Backpressure: register full, consumer stalled
    yr4 = 1'b0; iv4 = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall%0d_rdy", k), 32'(rdy4), 0);
      tick();
      chk($sformatf("stall%0d_y", k), 32'(y4), 32'h11);
      chk($sformatf("stall%0d_yv", k), 32'(yv4), 1);
      chk($sformatf("stall%0d_ych", k), 32'(ych4), 0);
    end
    yr4 = 1'b1;
    #1;
    chk("unstall_rdy", 32'(rdy4), 32'b0010);
    tick();
    chk("unstall_y", 32'(y4), 32'h22);
    chk("unstall_ych", 32'(ych4), 1);

`ifdef MUX_NTO1_XFER_CNT_EN
    iv4 = 4'b0000; cnt_clr = 1'b1;
    tick();
    chk("cnt_clr_idle", 32'(xfer_cnt), 0);
    cnt_clr = 1'b0; iv4 = 4'b1111;
    for (int k = 0; k < 5; k++) tick();
    chk("cnt_five", 32'(xfer_cnt), 5);
    cnt_clr = 1'b1;
    tick();
    chk("cnt_clr_wins", 32'(xfer_cnt), 0);
    chk("cnt_clr_xfer_yv", 32'(yv4), 1);
    cnt_clr = 1'b0;
`endif

    // Out-of-range direct select on the 3-channel instance
    iv3 = 3'b111; s3 = 2'd3; mode3 = 1'b0; yr3 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("oor%0d_rdy", k), 32'(rdy3), 0);
      tick();
      chk($sformatf("oor%0d_yv", k), 32'(yv3), 0);
    end
    s3 = 2'd2;
    #1;
    chk("ch3_rdy", 32'(rdy3), 32'b100);
    tick();
    chk("ch3_y", 32'(y3), 32'h33);
    chk("ch3_ych", 32'(ych3), 2);
    chk("ch3_yv", 32'(yv3), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
